// File: rtl/seq_det_pkg.sv
// Shared definitions for the 11011 sync detector family: capture FSM states,
// default widths and the sync pattern itself.
package seq_det_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } cap_state_t;

  localparam int PAYLOAD_W_DEF = 8;
  localparam int CNT_W_DEF     = 8;

  localparam logic [4:0] SYNC_PATTERN = 5'b11011;

endpackage

// File: rtl/sync_payload_capture_if.sv
// Valid/ready output channel carrying one captured payload word.
interface sync_payload_capture_if
  import seq_det_pkg::*;
#(
  parameter int PAYLOAD_W = PAYLOAD_W_DEF
);

  logic [PAYLOAD_W-1:0] data_o;
  logic                 valid;
  logic                 ready;

  modport master (output data_o, output valid, input ready);
  modport slave  (input data_o, input valid, output ready);

endinterface

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter
  import seq_det_pkg::*;
#(
  parameter int W = CNT_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (inc && (cnt_reg != '1)) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign cnt = cnt_reg;

endmodule

// File: rtl/sync_payload_capture.sv
// Captures PAYLOAD_W serial bits (MSB first) after each sync-match pulse and
// holds the word in a one-deep valid/ready output register.
module sync_payload_capture
  import seq_det_pkg::*;
#(
  parameter int PAYLOAD_W = PAYLOAD_W_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in,
  input  logic                      det,
  sync_payload_capture_if.master    bus,
  output logic                      busy,
  output logic [CNT_W-1:0]          frame_cnt,
  output logic [CNT_W-1:0]          drop_cnt
);

  localparam int BW = (PAYLOAD_W > 2) ? $clog2(PAYLOAD_W) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(PAYLOAD_W - 1);

  cap_state_t           state_reg, state_next;
  logic [PAYLOAD_W-1:0] shift_reg, shift_next;
  logic [BW-1:0]        bit_cnt_reg, bit_cnt_next;
  logic [PAYLOAD_W-1:0] data_reg;
  logic                 valid_reg;
  logic                 complete;
  logic                 handshake;
  logic                 drop_inc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      shift_reg   <= '0;
      bit_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      shift_reg   <= shift_next;
      bit_cnt_reg <= bit_cnt_next;
    end
  end

  // det is only looked at in IDLE: a sync pattern inside a payload is data.
  always_comb begin
    state_next   = state_reg;
    shift_next   = shift_reg;
    bit_cnt_next = bit_cnt_reg;
    complete     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (det) begin
          state_next   = SHIFT;
          bit_cnt_next = '0;
        end
      end
      SHIFT: begin
        shift_next   = PAYLOAD_W'({shift_reg, in});
        bit_cnt_next = bit_cnt_reg + 1'b1;
        if (bit_cnt_reg == LAST_BIT) begin
          complete   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign handshake = valid_reg && bus.ready;
  assign drop_inc  = complete && valid_reg && !bus.ready;

  // A finishing word may replace the held one only if that one leaves this edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_reg  <= '0;
      valid_reg <= 1'b0;
    end else if (complete && (!valid_reg || handshake)) begin
      data_reg  <= shift_next;
      valid_reg <= 1'b1;
    end else if (handshake) begin
      valid_reg <= 1'b0;
    end
  end

  assign bus.data_o = data_reg;
  assign bus.valid  = valid_reg;
  assign busy       = (state_reg == SHIFT);

  sat_counter #(.W(CNT_W)) u_frame_cnt (
    .clk (clk),
    .rst (rst),
    .inc (handshake),
    .cnt (frame_cnt)
  );

  sat_counter #(.W(CNT_W)) u_drop_cnt (
    .clk (clk),
    .rst (rst),
    .inc (drop_inc),
    .cnt (drop_cnt)
  );

endmodule

// File: tb/tb_sync_payload_capture.sv
// Bench for sync_payload_capture: directed frames plus random traffic, two
// instances (8-bit and 2-bit counters) checked against a behavioural model.
module tb_sync_payload_capture;
  import seq_det_pkg::*;

  localparam int PW = 8;

  logic clk;
  logic rst;
  logic in_s;
  logic det_s;
  logic ready_s;

  logic       busy8, busy2;
  logic [7:0] fc8, dc8;
  logic [1:0] fc2, dc2;

  sync_payload_capture_if #(.PAYLOAD_W(PW)) bus8 ();
  sync_payload_capture_if #(.PAYLOAD_W(PW)) bus2 ();

  assign bus8.ready = ready_s;
  assign bus2.ready = ready_s;

  sync_payload_capture #(.PAYLOAD_W(PW), .CNT_W(8)) dut8 (
    .clk       (clk),
    .rst       (rst),
    .in        (in_s),
    .det       (det_s),
    .bus       (bus8),
    .busy      (busy8),
    .frame_cnt (fc8),
    .drop_cnt  (dc8)
  );

  sync_payload_capture #(.PAYLOAD_W(PW), .CNT_W(2)) dut2 (
    .clk       (clk),
    .rst       (rst),
    .in        (in_s),
    .det       (det_s),
    .bus       (bus2),
    .busy      (busy2),
    .frame_cnt (fc2),
    .drop_cnt  (dc2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  function automatic logic [31:0] satv(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  // Behavioural model: count collected payload bits, build the word
  // arithmetically, and keep a one-entry output slot plus unbounded tallies.
  bit             m_cap;
  int             m_nbits;
  int             m_acc;
  logic [PW-1:0]  m_data;
  bit             m_valid;
  int             m_frames;
  int             m_drops;

  always @(posedge clk or posedge rst) begin
    bit hs;
    bit done;
    if (rst) begin
      m_cap = 0; m_nbits = 0; m_acc = 0;
      m_data = '0; m_valid = 0; m_frames = 0; m_drops = 0;
    end else begin
      hs   = m_valid && (ready_s == 1'b1);
      done = 0;
      if (m_cap) begin
        m_acc = m_acc * 2 + int'(in_s);
        m_nbits++;
        if (m_nbits == PW) begin
          done  = 1;
          m_cap = 0;
        end
      end else if (det_s) begin
        m_cap = 1; m_nbits = 0; m_acc = 0;
      end
      if (done) begin
        if (!m_valid || hs) begin
          m_data  = PW'(m_acc);
          m_valid = 1;
        end else begin
          m_drops++;
        end
      end else if (hs) begin
        m_valid = 0;
      end
      if (hs) m_frames++;
    end
  end

  always @(negedge clk) begin
    chk("busy8",  busy8,       m_cap);
    chk("valid8", bus8.valid,  m_valid);
    chk("data8",  bus8.data_o, m_data);
    chk("frame8", fc8,         satv(m_frames, 255));
    chk("drop8",  dc8,         satv(m_drops, 255));
    chk("busy2",  busy2,       m_cap);
    chk("valid2", bus2.valid,  m_valid);
    chk("data2",  bus2.data_o, m_data);
    chk("frame2", fc2,         satv(m_frames, 3));
    chk("drop2",  dc2,         satv(m_drops, 3));
  end

  // One clock: inputs apply to the next rising edge; returns 1 unit after it.
  task automatic cyc(input logic d, input logic i, input logic r);
    det_s = d; in_s = i; ready_s = r;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [PW-1:0] w, input logic r, input logic r_last);
    cyc(1'b1, 1'($urandom_range(0, 1)), r);
    for (int k = PW - 1; k >= 0; k--) begin
      cyc(1'b0, w[k], (k == 0) ? r_last : r);
    end
  endtask

  task automatic do_reset();
    #1;
    rst = 1'b1; det_s = 1'b0; in_s = 1'b0; ready_s = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [PW-1:0] w5a;
    rst = 1'b1; det_s = 1'b0; in_s = 1'b0; ready_s = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("reset_valid", bus8.valid, 1'b0);
    chk("reset_data",  bus8.data_o, 8'h00);
    chk("reset_busy",  busy8, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic frame
    do_reset();
    send(8'hA6, 1'b1, 1'b1);
    chk("basic_valid", bus8.valid, 1'b1);
    chk("basic_data",  bus8.data_o, 8'hA6);
    chk("basic_model", m_data, 8'hA6);
    cyc(1'b0, 1'b0, 1'b1);
    chk("basic_valid_drop", bus8.valid, 1'b0);
    chk("basic_frames", fc8, 8'd1);
    chk("basic_drops",  dc8, 8'd0);

    // Stalled consumer
    do_reset();
    send(8'h3C, 1'b0, 1'b0);
    chk("stall_first", bus8.data_o, 8'h3C);
    send(8'hF0, 1'b0, 1'b0);
    chk("stall_hold",  bus8.data_o, 8'h3C);
    chk("stall_valid", bus8.valid, 1'b1);
    chk("stall_drops", dc8, 8'd1);
    cyc(1'b0, 1'b0, 1'b1);
    chk("stall_release_valid", bus8.valid, 1'b0);
    chk("stall_release_frames", fc8, 8'd1);

    // Back-to-back handshake
    do_reset();
    send(8'h3C, 1'b0, 1'b0);
    send(8'hF0, 1'b0, 1'b1);
    chk("b2b_data",   bus8.data_o, 8'hF0);
    chk("b2b_valid",  bus8.valid, 1'b1);
    chk("b2b_drops",  dc8, 8'd0);
    chk("b2b_frames", fc8, 8'd1);
    cyc(1'b0, 1'b0, 1'b1);

    // det during SHIFT
    do_reset();
    w5a = 8'h5A;
    cyc(1'b1, 1'b0, 1'b0);
    for (int j = 1; j <= PW; j++) begin
      cyc((j == 3 || j == 7), w5a[PW - j], 1'b0);
      if (j == 4) chk("dshift_busy_mid", busy8, 1'b1);
    end
    chk("dshift_data", bus8.data_o, 8'h5A);
    chk("dshift_busy", busy8, 1'b0);
    repeat (4) cyc(1'b0, 1'($urandom_range(0, 1)), 1'b0);
    chk("dshift_no_restart", busy8, 1'b0);
    chk("dshift_no_drop", dc8, 8'd0);

    // Async reset mid-capture
    do_reset();
    send(8'hA6, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b1);
    send(8'h3C, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    repeat (4) cyc(1'b0, 1'b1, 1'b0);
    chk("areset_pre_busy", busy8, 1'b1);
    chk("areset_pre_frames", fc8, 8'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("areset_busy",   busy8, 1'b0);
    chk("areset_valid",  bus8.valid, 1'b0);
    chk("areset_frames", fc8, 8'd0);
    chk("areset_drops",  dc8, 8'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      cyc(1'b0, (k % 3) != 2, 1'b1);
    end
    chk("areset_after_valid", bus8.valid, 1'b0);
    chk("areset_after_busy",  busy8, 1'b0);

    // Saturation
    do_reset();
    repeat (5) begin
      send(8'($urandom), 1'b1, 1'b1);
      cyc(1'b0, 1'b0, 1'b1);
    end
    send(8'($urandom), 1'b0, 1'b0);
    repeat (5) send(8'($urandom), 1'b0, 1'b0);
    chk("sat_frame2", fc2, 2'd3);
    chk("sat_drop2",  dc2, 2'd3);
    chk("sat_frame8", fc8, 8'd5);
    chk("sat_drop8",  dc8, 8'd5);
    chk("sat_model_frames", 32'(m_frames), 32'd5);

    // Random traffic
    do_reset();
    for (int k = 0; k < 1500; k++) begin
      cyc(($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sync_payload_capture.md
Name: sync_payload_capture

Overview:
- Downstream consumer of the 11011 Mealy sync detector.
- Watches the detector's one-cycle match pulse together with the same serial bit stream.
- On each match, shifts in the next PAYLOAD_W serial bits MSB-first and presents the word on a valid/ready output register.
- Keeps saturating counts of delivered frames and of frames dropped because the consumer stalled.

Parameters:
PAYLOAD_W, 8, payload bits captured after each sync match (legal 2..32)
CNT_W, 8, width of frame_cnt and drop_cnt

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  reset, asynchronous, active-high
in  input  1  serial data bit, same stream fed to the detector
det  input  1  sync-match pulse from the detector, one cycle wide
data_o  output  PAYLOAD_W  captured payload, MSB = first bit after sync
valid  output  1  data_o holds an undelivered word
ready  input  1  consumer accepts data_o when valid && ready at clk edge
busy  output  1  capture FSM is in SHIFT
frame_cnt  output  CNT_W  words delivered (valid && ready handshakes), saturating
drop_cnt  output  CNT_W  completed captures discarded, saturating

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous and active-high on port rst.
- Reset values: state=IDLE, shift register=0, bit counter=0, data_o=0, valid=0, busy=0, frame_cnt=0, drop_cnt=0.
- Reset mid-capture discards the partial word. There is no partial output.
- Timing contract: the first payload bit is on `in` in the cycle after the cycle in which det is sampled high.
- Capture FSM, two states:
  - IDLE: busy=0. det=1 -> SHIFT, bit counter=0.
  - SHIFT: busy=1. Each cycle: shift register <= {shift[PAYLOAD_W-2:0], in}; bit counter++.
  - On the cycle the PAYLOAD_W-th bit is sampled (counter = PAYLOAD_W-1): completion event, -> IDLE.
- det while in SHIFT is ignored. There is no restart, because overlapping syncs inside a payload are data.
- det in the same cycle as completion is also ignored. The FSM returns to IDLE and waits for the next det.
- Capture latency: data_o/valid update at the edge ending the cycle of the last payload bit. valid rises PAYLOAD_W+1 cycles after the det cycle.
- Output register, evaluated per edge with completion C and handshake H = valid && ready:
  - C && (!valid || H): data_o <= new word, valid <= 1.
  - C && valid && !ready: new word discarded. data_o and valid are unchanged; drop_cnt++ (saturate at all-ones).
  - !C && H: valid <= 0; data_o holds its old value.
  - H in any case: frame_cnt++ (saturate at all-ones).
- Capture continues regardless of valid. The shift register is independent of the output register, giving one word of buffering: a new frame can be shifted in while the previous word waits.
- ready is don't-care while valid=0. Consumer-side stalls never stall the serial stream.
- Counters never wrap. Once at 2^CNT_W-1 they hold.
- No combinational path from any input to any output.

Decomposition:
- Shared package (seq_det_pkg):
  - capture state enum {IDLE, SHIFT}
  - defaults for PAYLOAD_W and CNT_W
  - the sync pattern constant 5'b11011, shared with the detector and the bench
- One natural sub-module: sat_counter (parameter W; inc, clear-on-reset; holds at max). Instantiated twice, for frame_cnt and drop_cnt.
- FSM, shift register and output register stay in the top module.

Test Plan:
- Basic frame:
  - Stimulus: reset, ready=1; drive det=1 for one cycle, then in=1,0,1,0,0,1,1,0 over the next 8 cycles.
  - Response: data_o=8'hA6, valid=1 for exactly one cycle, rising 9 cycles after det; frame_cnt=1, drop_cnt=0.
- Stalled consumer:
  - Stimulus: ready=0; capture 8'h3C, then a second det and capture 8'hF0.
  - Response: data_o stays 8'h3C, valid stays 1, drop_cnt=1. Then ready=1 for one cycle -> valid=0, frame_cnt=1.
- Back-to-back handshake:
  - Stimulus: the second frame completes in the same cycle that ready=1 accepts the first.
  - Response: data_o switches to the second word, valid stays 1, drop_cnt=0, frame_cnt=1.
- det during SHIFT:
  - Stimulus: pulse det at payload bits 3 and 7 of a capture of 8'h5A.
  - Response: data_o=8'h5A, busy deasserts on schedule, no second capture starts.
- Async reset mid-capture:
  - Stimulus: assert rst between clock edges at payload bit 4.
  - Response: immediately state=IDLE, busy=0, valid=0, both counters 0. After release, no output until the next det.
- Saturation:
  - Stimulus: CNT_W=2; deliver 5 frames, and force 5 drops.
  - Response: frame_cnt=3, drop_cnt=3, neither wraps to 0.
